// File: rtl/cpu_dma_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_dma_bus_arbiter_pkg
// Brief   : State encodings and helpers shared by the CPU/DMA bus arbiter.
// Revision: 1.0
// ============================================================================
package cpu_dma_bus_arbiter_pkg;

  localparam logic [1:0] kARB_ST_CPU   = 2'd0;
  localparam logic [1:0] kARB_ST_DMA   = 2'd1;
  localparam logic [1:0] kARB_ST_YIELD = 2'd2;

  localparam int unsigned BURST_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_CPU   = kARB_ST_CPU,
    ST_DMA   = kARB_ST_DMA,
    ST_YIELD = kARB_ST_YIELD
  } arb_state_e;

  // Burst counter sticks at all-ones rather than wrapping back to zero.
  function automatic logic [BURST_CNT_W-1:0] sat_inc(input logic [BURST_CNT_W-1:0] v);
    return (v == {BURST_CNT_W{1'b1}}) ? v : v + {{(BURST_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_dma_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : cpu_dma_bus_arbiter_if
// Brief   : CPU, DMA and memory bus signals around the bus arbiter.
// Revision: 1.0
// ============================================================================
interface cpu_dma_bus_arbiter_if;

  logic        cpu_sync;
  logic        cpu_hyper;
  logic [15:0] cpu_address;
  logic        cpu_write;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;

  logic        dma_req;
  logic [15:0] dma_address;
  logic        dma_write;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic        dma_ack;

  logic        mem_wait;
  logic [15:0] mem_address;
  logic        mem_write;
  logic [7:0]  mem_wdata;

  logic [1:0]  arb_state;

  modport slave (
    input  cpu_sync, cpu_hyper, cpu_address, cpu_write, cpu_wdata,
    input  dma_req, dma_address, dma_write, dma_wdata,
    input  mem_wait,
    output cpu_ready, dma_gnt, dma_ack,
    output mem_address, mem_write, mem_wdata,
    output arb_state
  );

  modport master (
    output cpu_sync, cpu_hyper, cpu_address, cpu_write, cpu_wdata,
    output dma_req, dma_address, dma_write, dma_wdata,
    output mem_wait,
    input  cpu_ready, dma_gnt, dma_ack,
    input  mem_address, mem_write, mem_wdata,
    input  arb_state
  );

endinterface
`default_nettype wire

// File: rtl/cpu_dma_bus_arbiter_bus_mux.sv
`default_nettype none
// ============================================================================
// Module  : arb_bus_mux
// Brief   : Combinational bus owner mux and handshake outputs.
// Revision: 1.0
// ============================================================================
module arb_bus_mux (
  input  wire logic        is_dma_i,
  input  wire logic [15:0] cpu_address_i,
  input  wire logic        cpu_write_i,
  input  wire logic [7:0]  cpu_wdata_i,
  input  wire logic        dma_req_i,
  input  wire logic [15:0] dma_address_i,
  input  wire logic        dma_write_i,
  input  wire logic [7:0]  dma_wdata_i,
  input  wire logic        mem_wait_i,
  output logic             cpu_ready_o,
  output logic             dma_gnt_o,
  output logic             dma_ack_o,
  output logic [15:0]      mem_address_o,
  output logic             mem_write_o,
  output logic [7:0]       mem_wdata_o
);

  always_comb begin
    if (is_dma_i) begin
      mem_address_o = dma_address_i;
      // An idle DMA-owned cycle must never strobe a write onto the bus.
      mem_write_o   = dma_write_i & dma_req_i;
      mem_wdata_o   = dma_wdata_i;
      cpu_ready_o   = 1'b0;
      dma_gnt_o     = 1'b1;
      dma_ack_o     = dma_req_i & ~mem_wait_i;
    end else begin
      mem_address_o = cpu_address_i;
      mem_write_o   = cpu_write_i;
      mem_wdata_o   = cpu_wdata_i;
      cpu_ready_o   = ~mem_wait_i;
      dma_gnt_o     = 1'b0;
      dma_ack_o     = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cpu_dma_bus_arbiter
// Brief   : Grants the memory bus to DMA at instruction boundaries with
//           capped bursts and a guaranteed CPU instruction between bursts.
// Revision: 1.0
// ============================================================================
module cpu_dma_bus_arbiter
  import cpu_dma_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  cpu_dma_bus_arbiter_if.slave  bus
);

  localparam logic [BURST_CNT_W-1:0] c_BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);

  arb_state_e               state_q, state_d;
  logic [BURST_CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                     w_is_dma;
  logic                     w_grant;

  assign w_is_dma = (state_q == ST_DMA);
  assign w_grant  = bus.dma_req & bus.cpu_sync & ~bus.mem_wait & ~bus.cpu_hyper;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CPU;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_CPU: begin
        if (w_grant) begin
          state_d     = ST_DMA;
          burst_cnt_d = '0;
        end
      end
      ST_DMA: begin
        if (!bus.mem_wait) begin
          if (bus.dma_req) begin
            burst_cnt_d = sat_inc(burst_cnt_q);
            if (burst_cnt_q == c_BURST_LAST) begin
              state_d = ST_YIELD;
            end
          end else begin
            state_d = ST_CPU;
          end
        end
      end
      // The sync that leaves this state only returns ownership; it never grants.
      ST_YIELD: begin
        if (bus.cpu_sync && !bus.mem_wait) begin
          state_d = ST_CPU;
        end
      end
      default: state_d = ST_CPU;
    endcase
  end

  assign bus.arb_state = state_q;

  arb_bus_mux u_bus_mux (
    .is_dma_i      (w_is_dma),
    .cpu_address_i (bus.cpu_address),
    .cpu_write_i   (bus.cpu_write),
    .cpu_wdata_i   (bus.cpu_wdata),
    .dma_req_i     (bus.dma_req),
    .dma_address_i (bus.dma_address),
    .dma_write_i   (bus.dma_write),
    .dma_wdata_i   (bus.dma_wdata),
    .mem_wait_i    (bus.mem_wait),
    .cpu_ready_o   (bus.cpu_ready),
    .dma_gnt_o     (bus.dma_gnt),
    .dma_ack_o     (bus.dma_ack),
    .mem_address_o (bus.mem_address),
    .mem_write_o   (bus.mem_write),
    .mem_wdata_o   (bus.mem_wdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_cpu_dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_dma_bus_arbiter
// Brief   : Directed and random stimulus against an ownership-level model.
// Revision: 1.0
// ============================================================================
module tb_cpu_dma_bus_arbiter;

  localparam int TB_MAX_BURST = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_dma_bus_arbiter_if bus ();

  cpu_dma_bus_arbiter #(.MAX_BURST(TB_MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who owns the bus, acks in the current grant, syncs that may not grant.
  bit m_dma  = 1'b0;
  int m_acks = 0;
  int m_skip = 0;

  int ack_seen = 0;
  int gnt_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_dma  = 1'b0;
      m_acks = 0;
      m_skip = 0;
    end else if (m_dma) begin
      if (!bus.mem_wait) begin
        if (bus.dma_req) begin
          if (m_acks < 255) m_acks++;
          if (m_acks == TB_MAX_BURST) begin
            m_dma  = 1'b0;
            m_skip = 1;
          end
        end else begin
          m_dma = 1'b0;
        end
      end
    end else if (bus.cpu_sync && !bus.mem_wait) begin
      if (m_skip > 0) m_skip--;
      else if (bus.dma_req && !bus.cpu_hyper) begin
        m_dma  = 1'b1;
        m_acks = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("cpu_ready", bus.cpu_ready, m_dma ? 32'd0 : {31'd0, ~bus.mem_wait});
    chk("dma_gnt", bus.dma_gnt, {31'd0, m_dma});
    chk("dma_ack", bus.dma_ack, {31'd0, m_dma & bus.dma_req & ~bus.mem_wait});
    chk("mem_address", bus.mem_address, {16'd0, m_dma ? bus.dma_address : bus.cpu_address});
    chk("mem_write", bus.mem_write, {31'd0, m_dma ? (bus.dma_req & bus.dma_write) : bus.cpu_write});
    chk("mem_wdata", bus.mem_wdata, {24'd0, m_dma ? bus.dma_wdata : bus.cpu_wdata});
    chk("arb_state", bus.arb_state, m_dma ? 32'd1 : (m_skip > 0 ? 32'd2 : 32'd0));
    chk("burst_cnt", dut.burst_cnt_q, m_acks);
    if (bus.dma_ack) ack_seen++;
    if (bus.dma_gnt) gnt_seen++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cpu(input logic [15:0] addr, input logic sync);
    bus.cpu_address = addr;
    bus.cpu_sync    = sync;
    bus.cpu_write   = 1'($urandom_range(0, 1)) & ~sync;
    bus.cpu_wdata   = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_sync = 0; bus.cpu_hyper = 0; bus.cpu_address = 16'h2000;
    bus.cpu_write = 0; bus.cpu_wdata = 0;
    bus.dma_req = 0; bus.dma_address = 16'h8000; bus.dma_write = 0; bus.dma_wdata = 0;
    bus.mem_wait = 0;
    @(posedge clk); #1;
    bus.mem_wait = 1'b1;
    cycle();
    bus.mem_wait = 1'b0;
    cycle();
    chk("reset_state", bus.arb_state, 32'd0);
    reset = 1'b0;

    // Idle DMA: CPU code with random wait states, DMA never requests.
    gnt_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cpu(16'h1000 + 16'(i), (i % 3) == 0);
      bus.mem_wait = ($urandom_range(0, 3) == 0);
      cycle();
    end
    chk("idle_no_gnt", gnt_seen, 32'd0);
    bus.mem_wait = 1'b0;

    // Grant at boundary, then burst cap with dma_req held high.
    bus.dma_write = 1'b1; bus.dma_wdata = 8'h5A; bus.dma_address = 16'h8100;
    cpu(16'h2003, 1'b0); bus.dma_req = 1'b1; cycle();
    cpu(16'h2004, 1'b0); cycle();
    chk("no_grant_midinsn", bus.arb_state, 32'd0);
    cpu(16'h2005, 1'b1); cycle();
    chk("grant_state", bus.arb_state, 32'd1);
    chk("grant_addr", bus.mem_address, 32'h8100);
    cpu(16'h2006, 1'b0);
    ack_seen = 0;
    for (int i = 0; i < TB_MAX_BURST; i++) begin
      bus.dma_address = 16'h8100 + 16'(i);
      cycle();
    end
    chk("burst_acks", ack_seen, TB_MAX_BURST);
    chk("yield_state", bus.arb_state, 32'd2);
    gnt_seen = 0;
    cpu(16'h2006, 1'b0); cycle();
    cpu(16'h2007, 1'b0); cycle();
    cpu(16'h2008, 1'b1); cycle();
    chk("yield_sync_no_grant", bus.arb_state, 32'd0);
    cpu(16'h2009, 1'b0); cycle();
    chk("yield_gnt_count", gnt_seen, 32'd0);
    cpu(16'h200A, 1'b1); cycle();
    chk("regrant_state", bus.arb_state, 32'd1);

    // Wait states on transfer #2.
    cpu(16'h200B, 1'b0);
    ack_seen = 0;
    cycle();
    bus.mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("wait_no_ack", ack_seen, 32'd1);
    bus.mem_wait = 1'b0;
    cycle();
    chk("wait_ack", ack_seen, 32'd2);
    chk("wait_burst_cnt", dut.burst_cnt_q, 32'd2);
    bus.dma_req = 1'b0;
    cycle();
    chk("drop_to_cpu", bus.arb_state, 32'd0);

    // Hypervisor blocks grants across 10 syncs.
    bus.cpu_hyper = 1'b1; bus.dma_req = 1'b1;
    gnt_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cpu(16'h3000 + 16'(2 * i), 1'b1); cycle();
      cpu(16'h3001 + 16'(2 * i), 1'b0); cycle();
    end
    chk("hyper_no_gnt", gnt_seen, 32'd0);
    bus.cpu_hyper = 1'b0;
    cpu(16'h3100, 1'b1); cycle();
    chk("hyper_release_grant", bus.arb_state, 32'd1);

    // Reset during transfer #3.
    cpu(16'h3101, 1'b0);
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_state", bus.arb_state, 32'd0);
    chk("rst_gnt", bus.dma_gnt, 32'd0);
    chk("rst_burst", dut.burst_cnt_q, 32'd0);
    bus.dma_req = 1'b0;
    cycle();

    // Random traffic, honouring the DMA hold rule while a transfer is stalled.
    for (int i = 0; i < 600; i++) begin
      bus.cpu_address = 16'($urandom);
      bus.cpu_sync    = ($urandom_range(0, 2) == 0);
      bus.cpu_write   = 1'($urandom_range(0, 1));
      bus.cpu_wdata   = 8'($urandom);
      bus.cpu_hyper   = ($urandom_range(0, 7) == 0);
      if (!(m_dma && bus.dma_req && bus.mem_wait)) begin
        bus.dma_req     = ($urandom_range(0, 3) != 0);
        bus.dma_address = 16'($urandom);
        bus.dma_write   = 1'($urandom_range(0, 1));
        bus.dma_wdata   = 8'($urandom);
      end
      bus.mem_wait = ($urandom_range(0, 3) == 0);
      reset        = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_dma_bus_arbiter.md
# cpu_dma_bus_arbiter

Shares the single 16-bit memory bus between the 65CE02 core and one DMA requester. The arbiter owns the core's `ready` input, grants the bus to DMA only at instruction boundaries, caps DMA bursts, and guarantees the CPU at least one full instruction between bursts. It sits between the core's `address`/`write`/`data_o` outputs and the memory/IO fabric.

## Interface
Parameters:
- MAX_BURST, 16, maximum DMA transfers per grant before a forced yield; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_sync  in  1  core `sync`; high during the opcode fetch cycle.
- cpu_hyper  in  1  core `hyper_mode`; while high, no new DMA grant is issued.
- cpu_address  in  16  core current-cycle address.
- cpu_write  in  1  core current-cycle write strobe.
- cpu_wdata  in  8  core `data_o`.
- cpu_ready  out  1  drives core `ready`.
- dma_req  in  1  DMA has a transfer presented; must stay high while dma_gnt & ~dma_ack.
- dma_address  in  16  DMA transfer address.
- dma_write  in  1  DMA transfer is a write.
- dma_wdata  in  8  DMA write data.
- dma_gnt  out  1  DMA owns the bus this cycle.
- dma_ack  out  1  DMA transfer completes this cycle.
- mem_wait  in  1  memory not ready; the current cycle is extended.
- mem_address  out  16  bus address.
- mem_write  out  1  bus write strobe.
- mem_wdata  out  8  bus write data.
- arb_state  out  2  current FSM state, for debug.

## Operation
- FSM states: ST_CPU (0), ST_DMA (1), ST_YIELD (2). Encoding 3 is illegal and recovers to ST_CPU.
- Bus mux:
  - Owner is CPU in ST_CPU and ST_YIELD: mem_* = cpu_*, cpu_ready = ~mem_wait, dma_gnt = 0, dma_ack = 0.
  - Owner is DMA in ST_DMA: mem_* = dma_*, cpu_ready = 0, dma_gnt = 1, dma_ack = dma_req & ~mem_wait.
  - In ST_DMA with dma_req low, the cycle is idle: mem_write forced to 0.
- ST_CPU → ST_DMA when dma_req & cpu_sync & ~mem_wait & ~cpu_hyper. The opcode fetch completes for the CPU. burst_cnt is cleared to 0.
- ST_DMA:
  - Each dma_ack increments burst_cnt.
  - dma_req low → ST_CPU after one idle cycle.
  - dma_ack with burst_cnt == MAX_BURST-1 → ST_YIELD.
  - mem_wait high freezes the state and burst_cnt.
- ST_YIELD: CPU owns the bus. A DMA request is ignored until cpu_sync & ~mem_wait; then → ST_CPU. That sync is never a grant point. The next sync is.
- Fairness consequence: after a forced yield, the CPU finishes its interrupted instruction plus one further complete instruction before DMA can regain the bus.
- burst_cnt width is 8 bits. It saturates and never wraps.
- While cpu_hyper is high, DMA is not granted. An in-progress burst is not pre-empted.
- dma_write & mem_write are never high while the CPU owns the bus. No cycle has both cpu_ready and dma_gnt high.

## Timing
- Reset: next edge gives state = ST_CPU and burst_cnt = 0; dma_gnt = 0, dma_ack = 0. cpu_ready = ~mem_wait, including during reset.
- Reset mid-burst: the grant is dropped the next cycle and the DMA abandons its transfer.
- Latency:
  - Grant takes effect the cycle after the qualifying sync cycle.
  - Return to the CPU is one cycle after the last ack. The CPU address is still held, so no reload bubble is needed.
- The bus mux is combinational from the registered state. Nothing is combinational from dma_req to cpu_ready.
- Simultaneous burst-limit reached and dma_req drop: ST_YIELD wins.
- mem_wait during a grant point: no transition; re-evaluated next cycle.

## Structure
- State encodings (kARB_ST_CPU/DMA/YIELD) go in the shared 65ce02 include header.
- Top-level FSM plus burst counter live in this module.
- One sub-module, `arb_bus_mux`, holds the combinational owner mux for mem_* and handshake outputs.

## Test plan
- **Idle DMA:** dma_req = 0 for 100 cycles of CPU code → cpu_ready follows ~mem_wait, dma_gnt never high, mem_address == cpu_address.
- **Grant at boundary:** dma_req rises mid-instruction at 0x2003, sync at 0x2005 → dma_gnt high the cycle after the 0x2005 fetch; cpu_ready = 0; mem_address = dma_address.
- **Burst cap:** MAX_BURST = 4 with dma_req held high → exactly 4 dma_ack, then ST_YIELD. The CPU completes the current instruction and the next one before dma_gnt reasserts.
- **Wait states:** mem_wait high for 3 cycles on DMA transfer #2 → dma_ack only in the 4th cycle; burst_cnt = 2 afterwards.
- **Hypervisor block:** cpu_hyper = 1 with dma_req high across 10 syncs → no grant; the first sync after cpu_hyper falls grants.
- **Reset mid-burst:** reset pulsed for 1 cycle during transfer #3 → state = ST_CPU, dma_gnt = 0, burst_cnt = 0 the next cycle.
